// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner: per-button FSM
// encoding, the ms-per-second constant and a compile-time max helper.
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } btn_state_e;

    localparam int MS_PER_SEC = 32'sd1000;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, press/release debounce FSM
// counting ms ticks, registered held level and one-clk press strobe.
module btn_debounce
    import btn_conditioner_pkg::*;
#(
    parameter int DB_MS = 20
) (
    input  logic clk,
    input  logic nRst,
    input  logic btn,
    input  logic ms_tick,
    output logic lvl,
    output logic press
);

    localparam int              DB_W    = $clog2(DB_MS + 32'sd1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_MS);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1'b1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(1'b0);

    logic            sync1_r;
    logic            sync2_r;
    btn_state_e      state_r;
    btn_state_e      state_s;
    logic [DB_W-1:0] cnt_r;
    logic [DB_W-1:0] cnt_s;
    logic [DB_W-1:0] cnt_inc_s;
    logic            lvl_r;
    logic            press_r;

    assign cnt_inc_s = (cnt_r == DB_LAST) ? cnt_r : cnt_r + DB_ONE;
    assign lvl       = lvl_r;
    assign press     = press_r;

    // Raw button into the clock domain; idles high (released)
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // FSM state, debounce count and registered outputs
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= ST_IDLE;
            cnt_r   <= DB_ZERO;
            lvl_r   <= 1'b0;
            press_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lvl_r   <= (state_s == ST_HELD) || (state_s == ST_DEB_REL);
            press_r <= (state_r == ST_DEB_PRESS) && (state_s == ST_HELD);
        end
    end

    // Next-state and debounce-count logic; any bounce restarts the window
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = DB_ZERO;
                if (!sync2_r) begin
                    state_s = ST_DEB_PRESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DEB_PRESS: begin
                if (sync2_r) begin
                    state_s = ST_IDLE;
                    cnt_s   = DB_ZERO;
                end else if (ms_tick && (cnt_inc_s == DB_LAST)) begin
                    state_s = ST_HELD;
                    cnt_s   = DB_ZERO;
                end else if (ms_tick) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_HELD: begin
                cnt_s = DB_ZERO;
                if (sync2_r) begin
                    state_s = ST_DEB_REL;
                end else begin
                    state_s = ST_HELD;
                end
            end
            ST_DEB_REL: begin
                if (!sync2_r) begin
                    state_s = ST_HELD;
                    cnt_s   = DB_ZERO;
                end else if (ms_tick && (cnt_inc_s == DB_LAST)) begin
                    state_s = ST_IDLE;
                    cnt_s   = DB_ZERO;
                end else if (ms_tick) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = DB_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/btn_conditioner.sv
// Two debounced push-buttons sharing a ms prescaler; inc auto-repeats while
// held, and next wins any same-cycle collision with an inc pulse.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int DB_MS   = 20,
    parameter int HOLD_MS = 500,
    parameter int RPT_MS  = 100
) (
    input  logic clk,
    input  logic nRst,
    input  logic inc,
    input  logic next,
    output logic inc_falling,
    output logic next_falling,
    output logic inc_lvl,
    output logic next_lvl
);

    localparam int               PRE_DIV  = CLK_HZ / MS_PER_SEC;
    localparam int               PRE_W    = (PRE_DIV > 32'sd1) ? $clog2(PRE_DIV) : 32'sd1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 32'sd1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(1'b0);
    localparam int               HR_MAX   = max_i(HOLD_MS, RPT_MS);
    localparam int               HR_W     = $clog2(HR_MAX + 32'sd1);
    localparam logic [HR_W-1:0]  HR_SAT   = HR_W'(HR_MAX);
    localparam logic [HR_W-1:0]  HOLD_END = HR_W'(HOLD_MS);
    localparam logic [HR_W-1:0]  RPT_END  = HR_W'(RPT_MS);
    localparam logic [HR_W-1:0]  HR_ONE   = HR_W'(1'b1);
    localparam logic [HR_W-1:0]  HR_ZERO  = HR_W'(1'b0);

    logic [PRE_W-1:0] pre_cnt_r;
    logic             ms_tick_r;
    logic             inc_lvl_s;
    logic             inc_press_s;
    logic             next_lvl_s;
    logic             next_press_s;
    logic [HR_W-1:0]  hr_cnt_r;
    logic [HR_W-1:0]  hr_cnt_s;
    logic [HR_W-1:0]  hr_inc_s;
    logic             rpt_phase_r;
    logic             rpt_phase_s;
    logic             rpt_fire_s;
    logic             rpt_r;
    logic             inc_falling_r;
    logic             next_falling_r;

    btn_debounce #(.DB_MS(DB_MS)) u_inc_db (
        .clk     (clk),
        .nRst    (nRst),
        .btn     (inc),
        .ms_tick (ms_tick_r),
        .lvl     (inc_lvl_s),
        .press   (inc_press_s)
    );

    btn_debounce #(.DB_MS(DB_MS)) u_next_db (
        .clk     (clk),
        .nRst    (nRst),
        .btn     (next),
        .ms_tick (ms_tick_r),
        .lvl     (next_lvl_s),
        .press   (next_press_s)
    );

    assign hr_inc_s     = (hr_cnt_r == HR_SAT) ? hr_cnt_r : hr_cnt_r + HR_ONE;
    assign inc_falling  = inc_falling_r;
    assign next_falling = next_falling_r;
    assign inc_lvl      = inc_lvl_s;
    assign next_lvl     = next_lvl_s;

    // Free-running prescaler producing the shared one-clk ms tick
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pre_cnt_r <= PRE_ZERO;
            ms_tick_r <= 1'b0;
        end else if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r <= PRE_ZERO;
            ms_tick_r <= 1'b1;
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
            ms_tick_r <= 1'b0;
        end
    end

    // Hold then repeat timing for inc; a held next parks it at zero
    always_comb begin
        hr_cnt_s    = hr_cnt_r;
        rpt_phase_s = rpt_phase_r;
        rpt_fire_s  = 1'b0;
        if (!inc_lvl_s || next_lvl_s) begin
            hr_cnt_s    = HR_ZERO;
            rpt_phase_s = 1'b0;
        end else if (ms_tick_r && !rpt_phase_r && (hr_inc_s == HOLD_END)) begin
            hr_cnt_s    = HR_ZERO;
            rpt_phase_s = 1'b1;
            rpt_fire_s  = 1'b1;
        end else if (ms_tick_r && rpt_phase_r && (hr_inc_s == RPT_END)) begin
            hr_cnt_s    = HR_ZERO;
            rpt_fire_s  = 1'b1;
        end else if (ms_tick_r) begin
            hr_cnt_s = hr_inc_s;
        end else begin
            hr_cnt_s = hr_cnt_r;
        end
    end

    // Repeat state and output pulses; a colliding inc pulse is dropped
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            hr_cnt_r       <= HR_ZERO;
            rpt_phase_r    <= 1'b0;
            rpt_r          <= 1'b0;
            inc_falling_r  <= 1'b0;
            next_falling_r <= 1'b0;
        end else begin
            hr_cnt_r       <= hr_cnt_s;
            rpt_phase_r    <= rpt_phase_s;
            rpt_r          <= rpt_fire_s;
            inc_falling_r  <= (inc_press_s | rpt_r) & ~next_press_s;
            next_falling_r <= next_press_s;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed and randomized press scenarios for btn_conditioner, checked against
// a ms-level timing model of debounce latency, hold delay and repeat period.
module tb_btn_conditioner;

    localparam int CLK_HZ  = 4000;
    localparam int DB_MS   = 3;
    localparam int HOLD_MS = 10;
    localparam int RPT_MS  = 4;
    localparam int CPM     = CLK_HZ / 1000;
    localparam int LAT_LO  = CPM * (DB_MS - 1);
    localparam int LAT_HI  = CPM * (DB_MS + 1) + 2;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    logic inc  = 1'b1;
    logic next = 1'b1;
    logic inc_falling;
    logic next_falling;
    logic inc_lvl;
    logic next_lvl;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int inc_q[$];
    int next_q[$];

    btn_conditioner #(
        .CLK_HZ  (CLK_HZ),
        .DB_MS   (DB_MS),
        .HOLD_MS (HOLD_MS),
        .RPT_MS  (RPT_MS)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .inc          (inc),
        .next         (next),
        .inc_falling  (inc_falling),
        .next_falling (next_falling),
        .inc_lvl      (inc_lvl),
        .next_lvl     (next_lvl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamp every cycle a pulse output is seen high
    always @(negedge clk) begin
        if (inc_falling === 1'b1) inc_q.push_back(cyc);
        if (next_falling === 1'b1) next_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit use_next, input logic v);
        if (use_next) next = v;
        else          inc  = v;
    endtask

    // Model: pulses at f, f+HOLD, then every RPT while the button is still held;
    // pulses up to the release are certain, up to the end of the release debounce possible.
    task automatic inc_model(input int f, input int r, output int n_sure, output int n_max);
        int t;
        n_sure = 1;
        n_max  = 1;
        t = f + CPM * HOLD_MS;
        while (t <= r + CPM * (DB_MS + 2)) begin
            if (t <= r + 1) n_sure++;
            n_max++;
            t += CPM * RPT_MS;
        end
    endtask

    task automatic run_press(input bit use_next, input int n_bounce, input int bounce_len,
                             input int hold_clks, output int p, output int r);
        int lo;
        int hi;
        int f;
        int n_sure;
        int n_max;
        inc_q.delete();
        next_q.delete();
        for (int b = 0; b < n_bounce; b++) begin
            lo = (bounce_len > 0) ? bounce_len : int'($urandom_range(1, LAT_LO - 1));
            hi = (bounce_len > 0) ? bounce_len : int'($urandom_range(1, LAT_LO - 1));
            drive(use_next, 1'b0);
            wait_clks(lo);
            drive(use_next, 1'b1);
            wait_clks(hi);
        end
        drive(use_next, 1'b0);
        p = cyc;
        wait_clks(CPM * (DB_MS + 2));
        chk("lvl_held", 32'(use_next ? next_lvl : inc_lvl), 32'd1);
        wait_clks(hold_clks - CPM * (DB_MS + 2));
        drive(use_next, 1'b1);
        r = cyc;
        wait_clks(CPM * (DB_MS + 4));
        chk("lvl_released", 32'(use_next ? next_lvl : inc_lvl), 32'd0);
        if (use_next) begin
            chk("next_count", next_q.size(), 32'd1);
            chk("next_no_inc", inc_q.size(), 32'd0);
            if (next_q.size() > 0) chk_rng("next_latency", next_q[0] - p, LAT_LO, LAT_HI);
        end else begin
            chk("inc_no_next", next_q.size(), 32'd0);
            f = (inc_q.size() > 0) ? inc_q[0] : p + CPM * DB_MS;
            inc_model(f, r, n_sure, n_max);
            chk_rng("inc_count", inc_q.size(), n_sure, n_max);
            if (inc_q.size() > 0) chk_rng("inc_latency", inc_q[0] - p, LAT_LO, LAT_HI);
            for (int i = 1; i < inc_q.size(); i++) begin
                chk("inc_rpt_gap", inc_q[i] - inc_q[i-1],
                    (i == 1) ? CPM * HOLD_MS : CPM * RPT_MS);
            end
        end
    endtask

    initial begin
        int p;
        int r;
        int q;
        int n_win;

        // Reset with inc already held: outputs quiet, full debounce afterwards
        inc = 1'b0;
        wait_clks(3);
        chk("rst_inc_falling", 32'(inc_falling), 32'd0);
        chk("rst_next_falling", 32'(next_falling), 32'd0);
        chk("rst_inc_lvl", 32'(inc_lvl), 32'd0);
        chk("rst_next_lvl", 32'(next_lvl), 32'd0);
        inc_q.delete();
        nRst = 1'b1;
        q = cyc;
        wait_clks(CPM * 8);
        inc = 1'b1;
        wait_clks(CPM * (DB_MS + 4));
        chk("rst_held_count", inc_q.size(), 32'd1);
        if (inc_q.size() > 0) chk_rng("rst_held_latency", inc_q[0] - q, LAT_LO, LAT_HI);

        // Clean inc press held 8 ms
        run_press(1'b0, 0, 0, CPM * 8, p, r);
        chk("clean_count", inc_q.size(), 32'd1);

        // next bouncing every 1 ms for 6 ms, then held low
        run_press(1'b1, 3, CPM, CPM * 8, p, r);

        // inc held 30 ms: six pulses within the hold
        run_press(1'b0, 0, 0, CPM * 30, p, r);
        n_win = 0;
        foreach (inc_q[i]) if (inc_q[i] <= r) n_win++;
        chk("rpt_in_30ms", n_win, 32'd6);

        // Simultaneous press: next wins, inc repeat suppressed, hold count restarts
        inc_q.delete();
        next_q.delete();
        inc  = 1'b0;
        next = 1'b0;
        p = cyc;
        wait_clks(CPM * 20);
        chk("sim_next_count", next_q.size(), 32'd1);
        chk("sim_inc_suppressed", inc_q.size(), 32'd0);
        if (next_q.size() > 0) chk_rng("sim_next_latency", next_q[0] - p, LAT_LO, LAT_HI);
        chk("sim_inc_lvl", 32'(inc_lvl), 32'd1);
        next = 1'b1;
        wait_clks(CPM * 8);
        chk("sim_after_next_rel", inc_q.size(), 32'd0);
        inc = 1'b1;
        wait_clks(CPM * (DB_MS + 4));
        chk("sim_final_inc", inc_q.size(), 32'd0);

        // Reset 2 ms into an inc debounce, button kept held
        inc_q.delete();
        inc = 1'b0;
        wait_clks(CPM * 2);
        nRst = 1'b0;
        wait_clks(2);
        chk("midrst_inc_falling", 32'(inc_falling), 32'd0);
        chk("midrst_inc_lvl", 32'(inc_lvl), 32'd0);
        nRst = 1'b1;
        q = cyc;
        wait_clks(CPM * 8);
        inc = 1'b1;
        wait_clks(CPM * (DB_MS + 4));
        chk("midrst_count", inc_q.size(), 32'd1);
        if (inc_q.size() > 0) chk_rng("midrst_latency", inc_q[0] - q, LAT_LO, LAT_HI);

        // Randomized presses: random button, bounce train and hold time
        for (int k = 0; k < 10; k++) begin
            run_press(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0,
                      int'($urandom_range(CPM * 6, CPM * 40)), p, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, giving the system clock frequency in Hz.
REQ-002 The block SHALL have parameter DB_MS, default 20, giving the debounce stability window in ms.
REQ-003 The block SHALL have parameter HOLD_MS, default 500, giving the inc hold time before auto-repeat starts.
REQ-004 The block SHALL have parameter RPT_MS, default 100, giving the inc auto-repeat period.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port nRst, input, 1 bit: reset, asynchronous assert and active-low.
REQ-007 The block SHALL have port inc, input, 1 bit: raw asynchronous push-button; 0 means pressed.
REQ-008 The block SHALL have port next, input, 1 bit: raw asynchronous push-button; 0 means pressed.
REQ-009 The block SHALL have port inc_falling, output, 1 bit: one-clk pulse for each accepted inc press and each auto-repeat.
REQ-010 The block SHALL have port next_falling, output, 1 bit: one-clk pulse for each accepted next press.
REQ-011 The block SHALL have ports inc_lvl and next_lvl, output, 1 bit each: debounced level, where 1 means held.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 A ms tick SHALL be a one-clk strobe every CLK_HZ/1000 clk cycles, from a free-running prescaler shared by both buttons.
REQ-014 Each button SHALL run a state machine with states IDLE, DEB_PRESS, HELD and DEB_REL.
- IDLE -> DEB_PRESS: synchronized input is 0.
- DEB_PRESS -> IDLE: input returns to 1 before DB_MS ticks.
- DEB_PRESS -> HELD: DB_MS consecutive ticks counted with input 0.
- HELD -> DEB_REL: input is 1.
- DEB_REL -> HELD: input returns to 0 before DB_MS ticks.
- DEB_REL -> IDLE: DB_MS ticks counted with input 1.
REQ-015 The press pulse SHALL assert for exactly one clk in the cycle after the DEB_PRESS -> HELD transition.
- There is no pulse on release.
- A bounce of any length shorter than DB_MS SHALL produce no pulse.
REQ-016 inc_lvl and next_lvl SHALL be 1 in HELD and DEB_REL, and 0 otherwise.
REQ-017 Auto-repeat is for inc only.
- After HOLD_MS ticks continuously in HELD/DEB_REL, inc_falling SHALL pulse once.
- It SHALL then pulse again every RPT_MS ticks until the button leaves HELD/DEB_REL.
- next SHALL never auto-repeat.
REQ-018 If inc and next would pulse in the same clk, next_falling SHALL assert and the inc pulse SHALL be dropped, not deferred.
REQ-019 While next_lvl = 1, inc auto-repeat SHALL be suppressed and its hold counter held at 0.
REQ-020 Tick counters SHALL saturate and never wrap.
- Debounce counter width: clog2(DB_MS+1).
- Hold/repeat counter width: clog2(max(HOLD_MS,RPT_MS)+1).
REQ-021 Both outputs SHALL be registered, with no combinational path from inc or next to any output.

Reset
REQ-022 While nRst = 0, all outputs SHALL be 0, both FSMs SHALL be IDLE, and all counters and synchronizer flops SHALL be at their idle value (sync flops = 1).
REQ-023 On nRst deassertion with a button already held, the block SHALL complete a full DB_MS debounce before the first pulse.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL discard the event without emitting a pulse.

Structure
REQ-025 The FSM state encoding and the ms-per-second constant (1000) SHALL live in a shared package used by the timer design.
REQ-026 One sub-module, btn_debounce, SHALL be instantiated twice.
- Contents: synchronizer, FSM, debounce counter.
- Outputs: level and press strobe.
REQ-027 The prescaler, auto-repeat logic and priority logic SHALL live in btn_conditioner.

Verification
REQ-028 The bench SHALL use CLK_HZ=4000 (4 clk/ms), DB_MS=3, HOLD_MS=10 and RPT_MS=4.
REQ-029 Clean press: inc held low 8 ms -> exactly one inc_falling pulse, 3 ticks (±1 tick) after the press; inc_lvl = 1; no pulse on release.
REQ-030 Bounce: next toggled every 1 ms for 6 ms, then held low -> exactly one next_falling pulse, 3 ticks after the final falling edge.
REQ-031 Auto-repeat: inc held 30 ms -> pulses at about 3, 13, 17, 21, 25 and 29 ms, six pulses in total.
REQ-032 Simultaneous press: inc and next pressed on the same clk -> next_falling = 1 and inc_falling = 0 on that cycle; inc repeats stay suppressed while next is held.
REQ-033 Reset mid-operation: nRst pulsed low at 2 ms into an inc debounce, button still held -> no pulse during reset; one pulse 3 ticks after release of reset.
